flash_boot_loader: RTL and testbench

FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

---
 rtl/flash_boot_pkg.sv | 24 ++
 rtl/flash_spi_phy.sv | 38 +++
 rtl/flash_boot_loader.sv | 142 ++++++++++++++
 tb/tb_flash_boot_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_boot_pkg.sv
// Shared constants and state encoding for the SPI flash boot loader.
package flash_boot_pkg;

  localparam logic [7:0]  READ_OPCODE = 8'h03;
  localparam int unsigned CMD_BITS    = 8;
  localparam int unsigned ADDR_BITS   = 24;
  localparam int unsigned DATA_BITS   = 32;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } boot_state_e;

  typedef logic [4:0] bit_cnt_t;

  // Index of the final bit of a field, in bit-counter width.
  function automatic bit_cnt_t last_bit(input int unsigned n);
    return bit_cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/flash_spi_phy.sv
// SPI mode-0 clock generator: SCK_DIV clk cycles per half period, with strobes for the rising and falling edges.
module flash_spi_phy #(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sck,
  output logic sample_tick,
  output logic shift_tick
);

  localparam logic [7:0] HALF_RELOAD = 8'(SCK_DIV - 1);

  logic [7:0] div_cnt;
  logic       half_end;

  // While disabled the divider parks at zero, so the first rising edge lands one clk after enable.
  assign half_end    = enable && (div_cnt == '0);
  assign sample_tick = half_end && !sck;
  assign shift_tick  = half_end && sck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (half_end) begin
      div_cnt <= HALF_RELOAD;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Boot loader: issues one SPI READ and streams WORD_COUNT words from flash into instruction RAM, holding the CPU in reset meanwhile.
module flash_boot_loader
  import flash_boot_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 1024,
  parameter int unsigned SCK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          flash_cs_n,
  output logic                          flash_sck,
  output logic                          flash_sdo,
  input  logic                          flash_sdi,
  output logic                          mem_we,
  output logic [$clog2(WORD_COUNT)-1:0] mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          cpu_rst,
  output logic                          boot_done
);

  localparam int unsigned   AW        = $clog2(WORD_COUNT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_COUNT - 1);

  boot_state_e state;
  logic [31:0] tx_shift;
  logic [30:0] rx_shift;
  bit_cnt_t    bit_cnt;
  logic        last_sampled;
  logic        tail;
  logic        phy_en;
  logic        sample_tick;
  logic        shift_tick;

  // tail freezes sck after the final falling edge while cs_n is still low for one more clk.
  assign phy_en    = !flash_cs_n && !tail;
  assign flash_sdo = tx_shift[31];

  flash_spi_phy #(
    .SCK_DIV(SCK_DIV)
  ) u_phy (
    .clk        (clk),
    .rst        (rst),
    .enable     (phy_en),
    .sck        (flash_sck),
    .sample_tick(sample_tick),
    .shift_tick (shift_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      flash_cs_n   <= 1'b1;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      last_sampled <= 1'b0;
      tail         <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      boot_done    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // The address advances the cycle after each strobe, except after the final word so it never wraps.
      if (mem_we && !last_sampled) begin
        mem_addr <= mem_addr + 1'b1;
      end

      case (state)
        IDLE: begin
          state      <= CMD;
          flash_cs_n <= 1'b0;
          tx_shift   <= {READ_OPCODE, FLASH_BASE};
          bit_cnt    <= '0;
        end

        CMD: begin
          if (shift_tick) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            if (bit_cnt == last_bit(CMD_BITS)) begin
              state   <= ADDR;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ADDR: begin
          if (shift_tick) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            if (bit_cnt == last_bit(ADDR_BITS)) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (sample_tick && !last_sampled) begin
            rx_shift <= {rx_shift[29:0], flash_sdi};
            if (bit_cnt == last_bit(DATA_BITS)) begin
              bit_cnt   <= '0;
              mem_we    <= 1'b1;
              mem_wdata <= {rx_shift, flash_sdi};
              if (mem_addr == LAST_ADDR) begin
                last_sampled <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          if (tail) begin
            state      <= DONE;
            flash_cs_n <= 1'b1;
            boot_done  <= 1'b1;
            cpu_rst    <= 1'b0;
            tail       <= 1'b0;
          end else if (shift_tick && last_sampled) begin
            tail <= 1'b1;
          end
        end

        DONE: begin
          flash_cs_n <= 1'b1;
          boot_done  <= 1'b1;
          cpu_rst    <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench: a 4-word flash image at SCK_DIV=2 plus a 2-word all-ones image at SCK_DIV=1.
module tb_flash_boot_loader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        flash_cs_n, flash_sck, flash_sdo, flash_sdi;
  logic        mem_we, cpu_rst, boot_done;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic        f_cs_n, f_sck, f_sdo, f_we, f_cpu_rst, f_boot_done;
  logic [0:0]  f_addr;
  logic [31:0] f_wdata;

  flash_boot_loader #(
    .WORD_COUNT(4),
    .SCK_DIV   (2),
    .FLASH_BASE(24'h000000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flash_cs_n(flash_cs_n),
    .flash_sck (flash_sck),
    .flash_sdo (flash_sdo),
    .flash_sdi (flash_sdi),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .boot_done (boot_done)
  );

  flash_boot_loader #(
    .WORD_COUNT(2),
    .SCK_DIV   (1),
    .FLASH_BASE(24'h000000)
  ) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .flash_cs_n(f_cs_n),
    .flash_sck (f_sck),
    .flash_sdo (f_sdo),
    .flash_sdi (1'b1),
    .mem_we    (f_we),
    .mem_addr  (f_addr),
    .mem_wdata (f_wdata),
    .cpu_rst   (f_cpu_rst),
    .boot_done (f_boot_done)
  );

  int checks   = 0;
  int failures = 0;

  // Flash image served by the behavioural SPI slave for the main instance.
  logic [31:0] words [4] = '{32'h3C000001, 32'h24020005, 32'hDEADBEEF, 32'h00000000};

  int          rise_cnt     = 0;
  int          k;
  logic [31:0] cmd_cap      = '0;
  logic [31:0] model_word   = '0;
  logic        model_sdi    = 1'b0;
  logic        sdi_override = 1'b0;
  logic        sdi_toggle   = 1'b0;
  logic        sck_at_cs    = 1'b0;
  time         t_cs_fall, t_rise0, t_rise1, t_last_fall, t_cs_rise;

  assign flash_sdi = sdi_override ? sdi_toggle : model_sdi;

  always @(negedge flash_cs_n) begin
    rise_cnt  = 0;
    cmd_cap   = '0;
    t_cs_fall = $time;
    sck_at_cs = flash_sck;
  end

  always @(posedge flash_cs_n) t_cs_rise = $time;

  always @(posedge flash_sck) begin
    if (rise_cnt == 0) t_rise0 = $time;
    if (rise_cnt == 1) t_rise1 = $time;
    if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], flash_sdo};
    rise_cnt++;
  end

  // Data bits change on sck falling edges, ready for the next rising-edge sample.
  always @(negedge flash_sck) begin
    t_last_fall = $time;
    if (rise_cnt >= 32 && rise_cnt < 160) begin
      k          = rise_cnt - 32;
      model_word = words[k / 32];
      model_sdi  = model_word[31 - (k % 32)];
    end
  end

  logic [31:0] wr_addr[$], wr_data[$], f_wr_addr[$], f_wr_data[$];
  int          done_cpu_skew = 0;
  int          idle_bad      = 0;
  int          f_rises       = 0;
  int          f_cmd_n       = 0;
  logic [31:0] f_cmd         = '0;
  int          writes_before;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (f_we === 1'b1) begin
      f_wr_addr.push_back(32'(f_addr));
      f_wr_data.push_back(f_wdata);
    end
    if (rst === 1'b1 && boot_done !== ~cpu_rst) done_cpu_skew++;
    if (sdi_override && (flash_cs_n !== 1'b1 || flash_sck !== 1'b0 || mem_we !== 1'b0)) idle_bad++;
  end

  always @(posedge f_sck) begin
    if (f_cs_n === 1'b0) f_rises++;
    if (f_cmd_n < 32) begin
      f_cmd = {f_cmd[30:0], f_sdo};
      f_cmd_n++;
    end
  end

  task automatic applyStimulus(input logic rst_val, input int cycles);
    rst = rst_val;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, 3);
    checkOutput("reset_cs_n", 32'(flash_cs_n), 32'd1);
    checkOutput("reset_sck", 32'(flash_sck), 32'd0);
    checkOutput("reset_sdo", 32'(flash_sdo), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("reset_boot_done", 32'(boot_done), 32'd0);

    applyStimulus(1'b1, 1);

    // Fast instance: continuous all-ones read at SCK_DIV=1.
    for (int i = 0; i < 2000 && f_boot_done !== 1'b1; i++) @(negedge clk);
    checkOutput("fast_boot_done", 32'(f_boot_done), 32'd1);
    checkOutput("fast_cpu_rst", 32'(f_cpu_rst), 32'd0);
    checkOutput("fast_sck_rises", 32'(f_rises), 32'd96);
    checkOutput("fast_cmd_bits", f_cmd, 32'h03000000);
    checkOutput("fast_write_count", 32'(f_wr_data.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("fast_addr%0d", i), f_wr_addr[i], 32'(i));
      checkOutput($sformatf("fast_data%0d", i), f_wr_data[i], 32'hFFFFFFFF);
    end

    // Main instance: four-word image at SCK_DIV=2.
    for (int i = 0; i < 2000 && boot_done !== 1'b1; i++) @(negedge clk);
    checkOutput("boot_done", 32'(boot_done), 32'd1);
    checkOutput("cpu_rst_released", 32'(cpu_rst), 32'd0);
    checkOutput("cs_n_after_boot", 32'(flash_cs_n), 32'd1);
    checkOutput("cmd_addr_bits", cmd_cap, 32'h03000000);
    checkOutput("sck_low_at_cs_fall", 32'(sck_at_cs), 32'd0);
    checkOutput("cs_fall_to_first_rise", 32'(t_rise0 - t_cs_fall), 32'd10);
    checkOutput("bit_period", 32'(t_rise1 - t_rise0), 32'd40);
    checkOutput("total_sck_rises", 32'(rise_cnt), 32'd160);
    checkOutput("last_fall_to_cs_rise", 32'(t_cs_rise - t_last_fall), 32'd10);
    checkOutput("write_count", 32'(wr_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("addr%0d", i), wr_addr[i], 32'(i));
      checkOutput($sformatf("data%0d", i), wr_data[i], words[i]);
    end

    // Restart the boot, then reset it during the 10th data bit of word 1.
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    for (int i = 0; i < 1000 && rise_cnt != 74; i++) @(negedge clk);
    checkOutput("reached_word1_bit10", 32'(rise_cnt), 32'd74);
    checkOutput("pre_reset_writes", 32'(wr_data.size()), 32'd5);
    wr_addr.delete();
    wr_data.delete();
    rst = 1'b0;
    #1;
    checkOutput("midreset_cs_n", 32'(flash_cs_n), 32'd1);
    checkOutput("midreset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midreset_sck", 32'(flash_sck), 32'd0);
    #29;
    checkOutput("midreset_no_writes", 32'(wr_data.size()), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 2000 && boot_done !== 1'b1; i++) @(negedge clk);
    checkOutput("reboot_done", 32'(boot_done), 32'd1);
    checkOutput("reboot_cmd_bits", cmd_cap, 32'h03000000);
    checkOutput("reboot_write_count", 32'(wr_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reboot_addr%0d", i), wr_addr[i], 32'(i));
      checkOutput($sformatf("reboot_data%0d", i), wr_data[i], words[i]);
    end

    // Once done, sdi activity must be ignored.
    writes_before = wr_data.size();
    sdi_override  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sdi_toggle = ~sdi_toggle;
      #50;
    end
    sdi_override = 1'b0;
    checkOutput("idle_rises", 32'(rise_cnt), 32'd160);
    checkOutput("idle_writes", 32'(wr_data.size() - writes_before), 32'd0);
    checkOutput("idle_glitches", 32'(idle_bad), 32'd0);
    checkOutput("idle_boot_done", 32'(boot_done), 32'd1);
    checkOutput("idle_cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("done_cpu_rst_same_cycle", 32'(done_cpu_skew), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
